// File: rtl/instruction_fetch.sv
// Sequential instruction fetch stage: PC register, one memory read per instruction, hand-off to decode.
// Optional macro FETCH_MISALIGN_CHECK_EN halts on a next PC that is not word aligned.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        clear_n,
  input  logic        start,
  input  logic        next_pc_valid,
  input  logic [31:0] next_pc,
  input  logic        next_pc_error,
  output logic        next_pc_ready,
  output logic        mem_req_valid,
  output logic [31:0] mem_req_address,
  input  logic        mem_req_ready,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  input  logic        mem_rsp_error,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  output logic [31:0] pc,
  output logic        halted,
  output logic [31:0] fetch_count
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    REQUEST  = 3'd1,
    WAIT_RSP = 3'd2,
    HOLD     = 3'd3,
    WAIT_PC  = 3'd4,
    HALT     = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic [31:0] fetch_count_q, fetch_count_d;
  logic        halted_q, halted_d;
  logic        misaligned;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign misaligned = (next_pc[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    fetch_count_d = fetch_count_q;
    halted_d      = halted_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = REQUEST;
      end
      REQUEST: begin
        if (mem_req_ready) state_d = WAIT_RSP;
      end
      WAIT_RSP: begin
        if (mem_rsp_valid) begin
          if (mem_rsp_error) begin
            halted_d = 1'b1;
            state_d  = HALT;
          end else begin
            instr_d    = mem_rsp_data;
            instr_pc_d = pc_q;
            state_d    = HOLD;
          end
        end
      end
      HOLD: begin
        if (instr_ready) begin
          fetch_count_d = fetch_count_q + 32'd1;
          state_d       = WAIT_PC;
        end
      end
      WAIT_PC: begin
        if (next_pc_valid) begin
          // A faulting next PC leaves pc untouched so the failing point stays visible.
          if (next_pc_error || misaligned) begin
            halted_d = 1'b1;
            state_d  = HALT;
          end else begin
            pc_d    = next_pc;
            state_d = REQUEST;
          end
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      instr_q       <= 32'd0;
      instr_pc_q    <= 32'd0;
      fetch_count_q <= 32'd0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      fetch_count_q <= fetch_count_d;
      halted_q      <= halted_d;
    end
  end

  // All outputs decode registered state only.
  assign mem_req_valid   = (state_q == REQUEST);
  assign instr_valid     = (state_q == HOLD);
  assign next_pc_ready   = (state_q == WAIT_PC);
  assign mem_req_address = {pc_q[31:2], 2'b00};
  assign instr           = instr_q;
  assign instr_pc        = instr_pc_q;
  assign pc              = pc_q;
  assign halted          = halted_q;
  assign fetch_count     = fetch_count_q;

endmodule
